bcd_counter_n: RTL and testbench
================================

Name: bcd_counter_n

Overview:
Parametrised multi-digit BCD up/down counter for the timer/display datapath. It is the successor of the single-digit 9-to-0 counter. It adds:
- a cascade of DIGITS decimal digits;
- a run-time direction select;
- a synchronous load;
- a configurable most-significant-digit limit (for example 5 for a minutes-tens digit);
- wrap or saturate at the terminal value;
- registered terminal flags for chaining to a downstream stage or a display/alarm FSM.

Parameters:
DIGITS, 2, number of cascaded BCD digits (1..8).
MSD_MAX, 9, maximum value of the most significant digit (1..9); all other digits run 0..9.
WRAP, 1, 1 = wrap at the terminal value; 0 = saturate and hold.

Ports:
clock_in  input  1  single system clock; rising edge active.
reset  input  1  asynchronous, active-low reset.
enable  input  1  count-step request, sampled on the rising edge.
end_condition  input  1  freeze; when high, count holds regardless of enable (load still works).
up_down  input  1  1 = count up, 0 = count down.
load  input  1  synchronous load strobe.
preset  input  4*DIGITS  BCD load value; digit i is bits [4i+3:4i].
count  output  4*DIGITS  current BCD value.
at_terminal  output  1  registered; high while count equals the terminal value for the current up_down.
terminal_pulse  output  1  registered one-cycle pulse when a step enters or crosses the terminal value.

Behaviour:
- Reset (reset=0, asynchronous): count=0, terminal_pulse=0. at_terminal reflects count=0, so it is 1 if up_down=0.
- Terminal value:
  - down: all digits 0;
  - up: MSD=MSD_MAX and all lower digits 9.
- Priority per edge: reset > load > (enable & !end_condition step) > hold.
- Load:
  - count <= preset with per-digit clamp: a lower digit >9 becomes 9; the MSD >MSD_MAX becomes MSD_MAX.
  - The result is visible the cycle after the edge.
  - Load never generates terminal_pulse.
- Step up:
  - Digit 0 increments; a digit at 9 becomes 0 and carries into the next digit.
  - The MSD carries out at MSD_MAX.
  - Carry out of the MSD is a terminal crossing: count becomes 0 if WRAP=1, or holds at the terminal value if WRAP=0.
- Step down:
  - Digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit.
  - A borrow out of the MSD is a terminal crossing: count becomes MSD_MAX,9..9 if WRAP=1, or holds at 0 if WRAP=0.
- terminal_pulse is 1 for exactly one cycle after any step whose result equals the terminal value, or after a crossing with WRAP=1.
- WRAP=0, stepping while already at the terminal value: count holds, terminal_pulse stays 0 (no repeated pulses).
- at_terminal is registered. It updates one cycle after count or up_down changes.
- up_down may change on any cycle. It takes effect for the step on the same edge. No pipeline flush is needed.
- end_condition=1 with enable=1: no step, terminal_pulse=0.
- Reset mid-count: immediate clear, independent of the clock. The first edge after release behaves as from count=0.
- Ripple carry/borrow is combinational within one cycle. There is a single cycle of latency from enable to the count update.

Decomposition:
- Shared package:
  - BCD_MAX=4'd9 constant;
  - bcd_digit_t 4-bit typedef;
  - function is_bcd_valid;
  - clamp function.
- Sub-module bcd_digit: one digit with inputs step_in, up_down, load, load_val and max_val, and outputs value and step_out (carry/borrow).
  - bcd_counter_n instantiates DIGITS of these in a generate loop, with max_val=9 except MSD_MAX for the top digit.
  - The top level adds terminal detection, the WRAP saturation override and the flag registers.

Test Plan:
- Reset, DIGITS=2, up_down=0: after reset release count=8'h00 and at_terminal=1. Hold enable=1 one cycle with WRAP=0 -> count stays 00, terminal_pulse=0.
- Load preset=8'h10, then down-count 10 cycles -> 09,08,...,00. terminal_pulse high only in the cycle after 01->00; at_terminal=1 from then on.
- WRAP=1, MSD_MAX=5, up_down=1, load 8'h58, step twice -> 59, then 00 with terminal_pulse=1 on the cycle after 59 is reached. The next step gives 01 with terminal_pulse=0.
- Clamp: load preset=8'hAF with MSD_MAX=5 -> count=8'h59. Load preset=8'h3C -> count=8'h39.
- end_condition=1 with enable=1 for 5 cycles at count 8'h42 -> count holds 42. Load of 8'h17 asserted during the freeze -> count=17.
- Asynchronous reset pulsed mid-cycle at count 8'h37 during down-count -> count=00 before the next edge. On release the bench sees normal stepping (99 if WRAP=1 with MSD_MAX=9).

Source files
------------

// File: rtl/bcd_counter_n_pkg.sv
// Shared BCD types and helpers for the multi-digit up/down counter.
package bcd_counter_n_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [3:0] bcd_digit_t;

  function automatic logic is_bcd_valid(bcd_digit_t d);
    return d <= BCD_MAX;
  endfunction

  // Out-of-range load values saturate to the digit's own ceiling.
  function automatic bcd_digit_t bcd_clamp(bcd_digit_t d, bcd_digit_t max_v);
    if (!is_bcd_valid(d) || d > max_v) return max_v;
    return d;
  endfunction

endpackage

// File: rtl/bcd_counter_n_digit.sv
// One BCD digit: load with clamp, step up/down, wrap at its own limit with carry/borrow out.
module bcd_digit
  import bcd_counter_n_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_in,
  input  logic       up_down,
  input  logic       load,
  input  bcd_digit_t load_val,
  input  bcd_digit_t max_val,
  output bcd_digit_t value,
  output bcd_digit_t value_nxt,
  output logic       step_out
);

  logic at_edge;

  assign at_edge  = up_down ? (value >= max_val) : (value == 4'd0);
  assign step_out = step_in & at_edge;

  always_comb begin
    value_nxt = value;
    if (load)
      value_nxt = bcd_clamp(load_val, max_val);
    else if (step_in) begin
      if (up_down) value_nxt = at_edge ? 4'd0 : value + 4'd1;
      else         value_nxt = at_edge ? max_val : value - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= '0;
    else        value <= value_nxt;

endmodule

// File: rtl/bcd_counter_n.sv
// Cascaded BCD up/down counter with load, MSD limit, wrap/saturate and registered terminal flags.
module bcd_counter_n
  import bcd_counter_n_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MSD_MAX = 9,
  parameter int WRAP    = 1
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  end_condition,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   preset,
  output logic [4*DIGITS-1:0]   count,
  output logic                  at_terminal,
  output logic                  terminal_pulse
);

  localparam bit WRAP_EN = (WRAP != 0);

  logic [DIGITS:0]             chain;
  logic [DIGITS-1:0][3:0]      val, val_nxt, term_up, term_now;
  logic                        at_term_now, step_req, pulse_nxt;

  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_digit
      localparam bcd_digit_t MAXV = (i == DIGITS-1) ? bcd_digit_t'(MSD_MAX) : BCD_MAX;
      assign term_up[i] = MAXV;
      bcd_digit u_digit (
        .clk       (clock_in),
        .rst_n     (reset),
        .step_in   (chain[i]),
        .up_down   (up_down),
        .load      (load),
        .load_val  (preset[4*i +: 4]),
        .max_val   (MAXV),
        .value     (val[i]),
        .value_nxt (val_nxt[i]),
        .step_out  (chain[i+1])
      );
    end
  endgenerate

  assign count       = val;
  assign term_now    = up_down ? term_up : '0;
  assign at_term_now = (val == term_now);
  assign step_req    = enable & ~end_condition & ~load;

  // A step from the terminal value is the only way to cross it, so blocking it here saturates.
  assign chain[0]  = step_req & ~(~WRAP_EN & at_term_now);
  assign pulse_nxt = chain[0] & ((val_nxt == term_now) | (WRAP_EN & chain[DIGITS]));

  always_ff @(posedge clock_in or negedge reset)
    if (!reset) terminal_pulse <= 1'b0;
    else        terminal_pulse <= pulse_nxt;

  // Left unreset so it keeps tracking count=0 against up_down while reset is held.
  always_ff @(posedge clock_in)
    at_terminal <= at_term_now;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench: three 2-digit counters (sat/9, wrap/5, wrap/9) share one stimulus stream.
module tb_bcd_counter_n;

  logic       clk = 1'b0;
  logic       reset, enable, end_condition, up_down, load;
  logic [7:0] preset;
  logic [7:0] c_sat, c_m5, c_w9;
  logic       at_sat, at_m5, at_w9, tp_sat, tp_m5, tp_w9;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(2), .MSD_MAX(9), .WRAP(0)) u_sat (
    .clock_in(clk), .reset(reset), .enable(enable), .end_condition(end_condition),
    .up_down(up_down), .load(load), .preset(preset), .count(c_sat),
    .at_terminal(at_sat), .terminal_pulse(tp_sat));

  bcd_counter_n #(.DIGITS(2), .MSD_MAX(5), .WRAP(1)) u_m5 (
    .clock_in(clk), .reset(reset), .enable(enable), .end_condition(end_condition),
    .up_down(up_down), .load(load), .preset(preset), .count(c_m5),
    .at_terminal(at_m5), .terminal_pulse(tp_m5));

  bcd_counter_n #(.DIGITS(2), .MSD_MAX(9), .WRAP(1)) u_w9 (
    .clock_in(clk), .reset(reset), .enable(enable), .end_condition(end_condition),
    .up_down(up_down), .load(load), .preset(preset), .count(c_w9),
    .at_terminal(at_w9), .terminal_pulse(tp_w9));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; preset = v;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; end_condition = 1'b0; up_down = 1'b0; load = 1'b0; preset = '0;
    repeat (3) tick();
    n_cmp++; if (c_sat !== 8'h00) begin n_err++; $display("FAIL reset_count got %h want 00", c_sat); end
    n_cmp++; if (tp_sat !== 1'b0) begin n_err++; $display("FAIL reset_pulse got %b want 0", tp_sat); end
    n_cmp++; if (at_sat !== 1'b1) begin n_err++; $display("FAIL reset_at_term got %b want 1", at_sat); end
    reset = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    n_cmp++; if (c_sat !== 8'h00) begin n_err++; $display("FAIL sat_hold_zero got %h want 00", c_sat); end
    n_cmp++; if (tp_sat !== 1'b0) begin n_err++; $display("FAIL sat_hold_pulse got %b want 0", tp_sat); end
    n_cmp++; if (c_w9 !== 8'h99) begin n_err++; $display("FAIL w9_borrow_wrap got %h want 99", c_w9); end
    n_cmp++; if (tp_w9 !== 1'b1) begin n_err++; $display("FAIL w9_borrow_pulse got %b want 1", tp_w9); end
    n_cmp++; if (c_m5 !== 8'h59) begin n_err++; $display("FAIL m5_borrow_wrap got %h want 59", c_m5); end
  endtask

  task automatic test_down_count();
    logic [7:0] exp;
    int v;
    up_down = 1'b0;
    do_load(8'h10);
    n_cmp++; if (c_sat !== 8'h10) begin n_err++; $display("FAIL down_load got %h want 10", c_sat); end
    n_cmp++; if (tp_sat !== 1'b0) begin n_err++; $display("FAIL down_load_pulse got %b want 0", tp_sat); end
    enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      v = 10 - k;
      exp = 8'((v / 10) * 16 + (v % 10));
      n_cmp++; if (c_sat !== exp) begin n_err++; $display("FAIL down_step%0d got %h want %h", k, c_sat, exp); end
      n_cmp++; if (tp_sat !== (v == 0)) begin n_err++; $display("FAIL down_pulse%0d got %b want %b", k, tp_sat, (v == 0)); end
    end
    enable = 1'b0;
    tick();
    n_cmp++; if (at_sat !== 1'b1) begin n_err++; $display("FAIL down_at_term got %b want 1", at_sat); end
    n_cmp++; if (tp_sat !== 1'b0) begin n_err++; $display("FAIL down_pulse_clear got %b want 0", tp_sat); end
  endtask

  task automatic test_wrap_up();
    up_down = 1'b1;
    do_load(8'h58);
    enable = 1'b1;
    tick();
    n_cmp++; if (c_m5 !== 8'h59) begin n_err++; $display("FAIL m5_up_59 got %h want 59", c_m5); end
    n_cmp++; if (tp_m5 !== 1'b1) begin n_err++; $display("FAIL m5_enter_pulse got %b want 1", tp_m5); end
    tick();
    n_cmp++; if (c_m5 !== 8'h00) begin n_err++; $display("FAIL m5_wrap_00 got %h want 00", c_m5); end
    n_cmp++; if (tp_m5 !== 1'b1) begin n_err++; $display("FAIL m5_wrap_pulse got %b want 1", tp_m5); end
    n_cmp++; if (c_sat !== 8'h60) begin n_err++; $display("FAIL sat_carry_60 got %h want 60", c_sat); end
    tick();
    n_cmp++; if (c_m5 !== 8'h01) begin n_err++; $display("FAIL m5_after_wrap got %h want 01", c_m5); end
    n_cmp++; if (tp_m5 !== 1'b0) begin n_err++; $display("FAIL m5_after_pulse got %b want 0", tp_m5); end
    enable = 1'b0;
  endtask

  task automatic test_clamp();
    do_load(8'hAF);
    n_cmp++; if (c_m5 !== 8'h59) begin n_err++; $display("FAIL m5_clamp_AF got %h want 59", c_m5); end
    n_cmp++; if (c_sat !== 8'h99) begin n_err++; $display("FAIL sat_clamp_AF got %h want 99", c_sat); end
    n_cmp++; if (tp_m5 !== 1'b0) begin n_err++; $display("FAIL clamp_no_pulse got %b want 0", tp_m5); end
    do_load(8'h3C);
    n_cmp++; if (c_m5 !== 8'h39) begin n_err++; $display("FAIL m5_clamp_3C got %h want 39", c_m5); end
    n_cmp++; if (c_sat !== 8'h39) begin n_err++; $display("FAIL sat_clamp_3C got %h want 39", c_sat); end
  endtask

  task automatic test_saturate_up();
    up_down = 1'b1;
    do_load(8'h99);
    tick();
    n_cmp++; if (at_sat !== 1'b1) begin n_err++; $display("FAIL sat_at_term_up got %b want 1", at_sat); end
    enable = 1'b1;
    tick();
    enable = 1'b0;
    n_cmp++; if (c_sat !== 8'h99) begin n_err++; $display("FAIL sat_hold_99 got %h want 99", c_sat); end
    n_cmp++; if (tp_sat !== 1'b0) begin n_err++; $display("FAIL sat_no_repulse got %b want 0", tp_sat); end
    n_cmp++; if (c_w9 !== 8'h00) begin n_err++; $display("FAIL w9_carry_wrap got %h want 00", c_w9); end
    n_cmp++; if (tp_w9 !== 1'b1) begin n_err++; $display("FAIL w9_carry_pulse got %b want 1", tp_w9); end
    up_down = 1'b0;
    tick();
    n_cmp++; if (at_sat !== 1'b0) begin n_err++; $display("FAIL sat_at_term_dir got %b want 0", at_sat); end
  endtask

  task automatic test_carry();
    up_down = 1'b1;
    do_load(8'h19);
    enable = 1'b1;
    tick();
    n_cmp++; if (c_w9 !== 8'h20) begin n_err++; $display("FAIL carry_19_20 got %h want 20", c_w9); end
    up_down = 1'b0;
    tick();
    n_cmp++; if (c_w9 !== 8'h19) begin n_err++; $display("FAIL borrow_20_19 got %h want 19", c_w9); end
    enable = 1'b0;
  endtask

  task automatic test_freeze();
    up_down = 1'b0;
    do_load(8'h42);
    end_condition = 1'b1; enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if (c_sat !== 8'h42) begin n_err++; $display("FAIL freeze_hold%0d got %h want 42", k, c_sat); end
      n_cmp++; if (tp_sat !== 1'b0) begin n_err++; $display("FAIL freeze_pulse%0d got %b want 0", k, tp_sat); end
    end
    do_load(8'h17);
    n_cmp++; if (c_sat !== 8'h17) begin n_err++; $display("FAIL freeze_load got %h want 17", c_sat); end
    end_condition = 1'b0; enable = 1'b0;
  endtask

  task automatic test_async_reset();
    up_down = 1'b0;
    do_load(8'h37);
    enable = 1'b1;
    tick();
    n_cmp++; if (c_w9 !== 8'h36) begin n_err++; $display("FAIL pre_reset_step got %h want 36", c_w9); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (c_w9 !== 8'h00) begin n_err++; $display("FAIL async_clear_w9 got %h want 00", c_w9); end
    n_cmp++; if (c_sat !== 8'h00) begin n_err++; $display("FAIL async_clear_sat got %h want 00", c_sat); end
    reset = 1'b1;
    tick();
    n_cmp++; if (c_w9 !== 8'h99) begin n_err++; $display("FAIL post_reset_w9 got %h want 99", c_w9); end
    n_cmp++; if (tp_w9 !== 1'b1) begin n_err++; $display("FAIL post_reset_pulse got %b want 1", tp_w9); end
    n_cmp++; if (c_sat !== 8'h00) begin n_err++; $display("FAIL post_reset_sat got %h want 00", c_sat); end
    tick();
    n_cmp++; if (c_w9 !== 8'h98) begin n_err++; $display("FAIL post_reset_w9_2 got %h want 98", c_w9); end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_down_count();
    test_wrap_up();
    test_clamp();
    test_saturate_up();
    test_carry();
    test_freeze();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
